// File: rtl/msft_dv_debug_apb_master_seq_pkg.sv
// Shared debug-APB definitions: command/response layout, access op codes and sequencer states.
package msft_dv_debug_apb_master_seq_pkg;

   localparam int APB_CMD_WIDTH  = 65;
   localparam int APB_RESP_WIDTH = 36;

   // cmd_i layout for full rd/wr requests
   localparam int CMD_WRITE    = 64;
   localparam int CMD_ADDR_MSB = 63;
   localparam int CMD_ADDR_LSB = 32;

   // resp_o layout
   localparam int RESP_BUSY   = 35;
   localparam int RESP_TMO    = 34;
   localparam int RESP_SLVERR = 33;
   localparam int RESP_PROTO  = 32;

   localparam logic [1:0] REQ_RDWR = 2'b01;
   localparam logic [1:0] REQ_ACC  = 2'b10;
   localparam logic [1:0] REQ_BAD  = 2'b11;

   localparam logic [1:0] OP_STATUS = 2'd0;
   localparam logic [1:0] OP_CLEAR  = 2'd1;
   localparam logic [1:0] OP_INC    = 2'd2;
   localparam logic [1:0] OP_RSVD   = 2'd3;

   localparam logic [31:0] TMO_RDATA = 32'hDEAD_BEEF;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   function automatic logic [3:0] strb_for(input logic wr);
      return wr ? 4'hF : 4'h0;
   endfunction

endpackage

// File: rtl/msft_dv_debug_apb_master_seq_if.sv
// APB bus between the debug sequencer (master) and the fabric/slave side.
interface msft_dv_debug_apb_master_seq_if;
   logic [31:0] paddr;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   logic [2:0]  pprot;
   logic [31:0] prdata;
   logic        pready;
   logic        pslverr;

   modport master (
      output paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
      output prdata, pready, pslverr
   );
endinterface

// File: rtl/msft_dv_debug_apb_master_seq.sv
// Debug APB master sequencer: turns one-shot JTAG bridge requests into APB SETUP/ACCESS cycles
// with sticky error status, address auto-increment and a PREADY timeout.
module msft_dv_debug_apb_master_seq
   import msft_dv_debug_apb_master_seq_pkg::*;
#(
   parameter int          TIMEOUT_W = 8,
   parameter logic [31:0] ADDR_INC  = 32'd4,
   parameter logic [2:0]  PPROT     = 3'b010
) (
   input  logic                      clk,
   input  logic                      TRSTn,
   input  logic [1:0]                req_i,
   output logic                      ack_o,
   input  logic [APB_CMD_WIDTH-1:0]  cmd_i,
   output logic [APB_RESP_WIDTH-1:0] resp_o,
   msft_dv_debug_apb_master_seq_if.master apb
);

   // TRSTn is unrelated to clk: assert immediately, release only after two clk flops
   logic r_rst_meta;
   logic r_rst_n;

   always_ff @(posedge clk or negedge TRSTn) begin
      if (!TRSTn) begin
         r_rst_meta <= 1'b0;
         r_rst_n    <= 1'b0;
      end else begin
         r_rst_meta <= 1'b1;
         r_rst_n    <= r_rst_meta;
      end
   end

   state_e               r_state;
   logic                 r_ack;
   logic                 r_psel;
   logic                 r_penable;
   logic                 r_write;
   logic [31:0]          r_addr;
   logic [31:0]          r_wdata;
   logic [31:0]          r_rdata;
   logic                 r_tmo;
   logic                 r_slverr;
   logic                 r_proto;
   logic [TIMEOUT_W-1:0] r_tmo_cnt;

   logic [TIMEOUT_W-1:0] w_cnt_nxt;
   logic                 w_tmo_hit;

   assign w_cnt_nxt = r_tmo_cnt + 1'b1;
   // Abort on the ACCESS cycle where the count would reach all-ones
   assign w_tmo_hit = &w_cnt_nxt;

   always_ff @(posedge clk or negedge r_rst_n) begin
      if (!r_rst_n) begin
         r_state   <= ST_IDLE;
         r_ack     <= 1'b0;
         r_psel    <= 1'b0;
         r_penable <= 1'b0;
         r_write   <= 1'b0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_rdata   <= '0;
         r_tmo     <= 1'b0;
         r_slverr  <= 1'b0;
         r_proto   <= 1'b0;
         r_tmo_cnt <= '0;
      end else begin
         r_ack <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_tmo_cnt <= '0;
               case (req_i)
                  REQ_RDWR: begin
                     r_write <= cmd_i[CMD_WRITE];
                     r_addr  <= cmd_i[CMD_ADDR_MSB:CMD_ADDR_LSB];
                     r_wdata <= cmd_i[31:0];
                     r_psel  <= 1'b1;
                     r_state <= ST_SETUP;
                  end
                  REQ_ACC: begin
                     case (cmd_i[1:0])
                        OP_CLEAR: begin
                           r_tmo    <= 1'b0;
                           r_slverr <= 1'b0;
                           r_proto  <= 1'b0;
                           r_ack    <= 1'b1;
                           r_state  <= ST_DONE;
                        end
                        OP_INC: begin
                           // replays the previous direction/data at the next address
                           r_addr  <= r_addr + ADDR_INC;
                           r_psel  <= 1'b1;
                           r_state <= ST_SETUP;
                        end
                        default: begin
                           r_ack   <= 1'b1;
                           r_state <= ST_DONE;
                        end
                     endcase
                  end
                  REQ_BAD: begin
                     r_proto <= 1'b1;
                     r_ack   <= 1'b1;
                     r_state <= ST_DONE;
                  end
                  default: ;
               endcase
            end
            ST_SETUP: begin
               r_penable <= 1'b1;
               r_state   <= ST_ACCESS;
            end
            ST_ACCESS: begin
               r_tmo_cnt <= w_cnt_nxt;
               if (apb.pready) begin
                  if (!r_write) r_rdata <= apb.prdata;
                  if (apb.pslverr) r_slverr <= 1'b1;
                  r_psel    <= 1'b0;
                  r_penable <= 1'b0;
                  r_ack     <= 1'b1;
                  r_state   <= ST_DONE;
               end else if (w_tmo_hit) begin
                  r_rdata   <= TMO_RDATA;
                  r_tmo     <= 1'b1;
                  r_psel    <= 1'b0;
                  r_penable <= 1'b0;
                  r_ack     <= 1'b1;
                  r_state   <= ST_DONE;
               end
            end
            ST_DONE: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign ack_o       = r_ack;
   assign apb.paddr   = r_addr;
   assign apb.psel    = r_psel;
   assign apb.penable = r_penable;
   assign apb.pwrite  = r_write;
   assign apb.pwdata  = r_wdata;
   assign apb.pstrb   = strb_for(r_write);
   assign apb.pprot   = PPROT;

   always_comb begin
      resp_o              = '0;
      resp_o[RESP_BUSY]   = (r_state != ST_IDLE);
      resp_o[RESP_TMO]    = r_tmo;
      resp_o[RESP_SLVERR] = r_slverr;
      resp_o[RESP_PROTO]  = r_proto;
      resp_o[31:0]        = r_rdata;
   end

endmodule

// File: tb/tb_msft_dv_debug_apb_master_seq.sv
// Bench for the debug APB sequencer: directed scenarios plus random requests against a
// transaction-level model of the sticky status, address register and expected bus cycle.
module tb_msft_dv_debug_apb_master_seq;

   localparam int TW      = 3;
   localparam int TMO_CYC = (1 << TW) - 1;

   logic        clk = 1'b0;
   logic        TRSTn = 1'b0;
   logic [1:0]  req_i = 2'b00;
   logic        ack_o;
   logic [64:0] cmd_i = '0;
   logic [35:0] resp_o;

   msft_dv_debug_apb_master_seq_if apb ();

   msft_dv_debug_apb_master_seq #(.TIMEOUT_W(TW), .ADDR_INC(32'd4), .PPROT(3'b010)) dut (
      .clk    (clk),
      .TRSTn  (TRSTn),
      .req_i  (req_i),
      .ack_o  (ack_o),
      .cmd_i  (cmd_i),
      .resp_o (resp_o),
      .apb    (apb)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // transaction-level model state
   logic [31:0] m_addr, m_wdata, m_rdata;
   logic        m_write, m_to, m_slv, m_proto;
   logic [31:0] last_addr;
   int          last_acc;

   task automatic model_reset();
      m_addr = '0; m_wdata = '0; m_rdata = '0;
      m_write = 1'b0; m_to = 1'b0; m_slv = 1'b0; m_proto = 1'b0;
   endtask

   // One request: dly = extra wait cycles before PREADY, hang = slave never answers
   task automatic run(input string nm, input logic [1:0] req, input logic [64:0] cmd,
                      input int dly, input bit hang, input logic [31:0] rd, input bit serr);
      bit          bus = 0;
      bit          got = 0;
      bit          unstable = 0;
      int          lat = 0, n_setup = 0, n_acc = 0, exp_acc, exp_lat;
      logic [31:0] s_addr = '0, s_wd = '0;
      logic        s_wr = 1'b0;
      logic [3:0]  s_strb = '0;
      logic [35:0] exp_resp;

      case (req)
         2'b01: begin
            bus = 1; m_write = cmd[64]; m_addr = cmd[63:32]; m_wdata = cmd[31:0];
         end
         2'b10: begin
            if (cmd[1:0] == 2'd1) begin m_to = 0; m_slv = 0; m_proto = 0; end
            if (cmd[1:0] == 2'd2) begin bus = 1; m_addr = m_addr + 32'd4; end
         end
         2'b11: m_proto = 1;
         default: ;
      endcase
      exp_acc = !bus ? 0 : (hang ? TMO_CYC : dly + 1);
      exp_lat = bus ? 2 + exp_acc : 1;

      @(negedge clk);
      req_i = req; cmd_i = cmd;
      for (int c = 1; c <= 40 && !got; c++) begin
         @(negedge clk);
         if (ack_o) begin
            got = 1; lat = c;
         end else begin
            cmd_i = {1'($urandom), $urandom, $urandom};
         end
         if (apb.psel && !apb.penable) begin
            n_setup++; s_addr = apb.paddr; s_wr = apb.pwrite; s_strb = apb.pstrb; s_wd = apb.pwdata;
         end
         if (apb.psel && apb.penable) begin
            n_acc++;
            if (apb.paddr !== s_addr || apb.pwrite !== s_wr || apb.pwdata !== s_wd || apb.pstrb !== s_strb)
               unstable = 1;
            if (!hang && n_acc == dly + 1) begin
               apb.pready = 1'b1; apb.prdata = rd; apb.pslverr = serr;
            end else begin
               apb.pready = 1'b0; apb.prdata = $urandom; apb.pslverr = 1'($urandom);
            end
         end else begin
            apb.pready = 1'b0; apb.pslverr = 1'b0;
         end
         if (got) begin
            chk({nm, "_busy_at_ack"}, 64'(resp_o[35]), 64'd1);
            req_i = 2'b00;
         end
      end
      chk({nm, "_ack_seen"}, 64'(got), 64'd1);
      if (!got) req_i = 2'b00;
      chk({nm, "_latency"}, 64'(lat), 64'(exp_lat));

      if (bus) begin
         if (hang) begin
            m_to = 1; m_rdata = 32'hDEAD_BEEF;
         end else begin
            if (!m_write) m_rdata = rd;
            if (serr) m_slv = 1;
         end
      end
      exp_resp = {1'b0, m_to, m_slv, m_proto, m_rdata};

      @(negedge clk);
      chk({nm, "_ack_pulse"}, 64'(ack_o), 64'd0);
      chk({nm, "_resp"}, 64'(resp_o), 64'(exp_resp));
      chk({nm, "_n_setup"}, 64'(n_setup), bus ? 64'd1 : 64'd0);
      chk({nm, "_n_access"}, 64'(n_acc), 64'(exp_acc));
      if (bus) begin
         chk({nm, "_paddr"}, 64'(s_addr), 64'(m_addr));
         chk({nm, "_pwrite"}, 64'(s_wr), 64'(m_write));
         chk({nm, "_pstrb"}, 64'(s_strb), m_write ? 64'hF : 64'h0);
         chk({nm, "_pwdata"}, 64'(s_wd), 64'(m_wdata));
         chk({nm, "_stable"}, 64'(unstable), 64'd0);
      end
      last_addr = s_addr;
      last_acc  = n_acc;
   endtask

   function automatic logic [64:0] acc_cmd(input logic [1:0] op);
      logic [64:0] c;
      c = {1'($urandom), $urandom, $urandom};
      c[1:0] = op;
      return c;
   endfunction

   initial begin
      apb.pready = 1'b0; apb.prdata = '0; apb.pslverr = 1'b0;
      model_reset();

      repeat (3) @(negedge clk);
      chk("rst_resp", 64'(resp_o), 64'd0);
      chk("rst_psel", 64'({apb.psel, apb.penable, ack_o}), 64'd0);
      chk("rst_paddr", 64'(apb.paddr), 64'd0);
      chk("pprot", 64'(apb.pprot), 64'h2);
      TRSTn = 1'b1;
      repeat (3) @(negedge clk);

      // 1 write
      run("t1_wr", 2'b01, {1'b1, 32'h4000_0010, 32'hCAFE_F00D}, 0, 0, 32'h0, 0);
      chk("t1_resp_err", 64'(resp_o[35:32]), 64'd0);
      // 2 read with waits
      run("t2_rd", 2'b01, {1'b0, 32'h4000_0020, 32'h0}, 5, 0, 32'h1234_5678, 0);
      chk("t2_penable_cycles", 64'(last_acc), 64'd6);
      chk("t2_rdata", 64'(resp_o[31:0]), 64'h1234_5678);
      // 3 auto-increment
      run("t3_inc1", 2'b10, acc_cmd(2'd2), 1, 0, 32'h1111_0024, 0);
      chk("t3_addr1", 64'(last_addr), 64'h4000_0024);
      run("t3_inc2", 2'b10, acc_cmd(2'd2), 0, 0, 32'h1111_0028, 0);
      chk("t3_addr2", 64'(last_addr), 64'h4000_0028);
      run("t3_inc3", 2'b10, acc_cmd(2'd2), 2, 0, 32'h1111_002C, 0);
      chk("t3_addr3", 64'(last_addr), 64'h4000_002C);
      run("t3_top", 2'b01, {1'b0, 32'hFFFF_FFFC, 32'h0}, 0, 0, 32'h5A5A_5A5A, 0);
      run("t3_wrap", 2'b10, acc_cmd(2'd2), 0, 0, 32'hA5A5_A5A5, 0);
      chk("t3_wrap_addr", 64'(last_addr), 64'h0);
      // 4 timeout
      run("t4_tmo", 2'b01, {1'b0, 32'h4000_0040, 32'h0}, 0, 1, 32'h0, 0);
      chk("t4_tmo_bit", 64'(resp_o[34]), 64'd1);
      chk("t4_rdata", 64'(resp_o[31:0]), 64'hDEAD_BEEF);
      run("t4_status", 2'b10, acc_cmd(2'd0), 0, 0, 32'h0, 0);
      chk("t4_keep", 64'(resp_o[34]), 64'd1);
      run("t4_clear", 2'b10, acc_cmd(2'd1), 0, 0, 32'h0, 0);
      chk("t4_cleared", 64'(resp_o[34]), 64'd0);
      // 5 errors
      run("t5_slverr", 2'b01, {1'b1, 32'h4000_0050, 32'h0BAD_0BAD}, 1, 0, 32'h0, 1);
      chk("t5_slv_bit", 64'(resp_o[33]), 64'd1);
      run("t5_proto", 2'b11, acc_cmd(2'd0), 0, 0, 32'h0, 0);
      chk("t5_proto_bit", 64'(resp_o[32]), 64'd1);

      // 6 reset in the middle of ACCESS
      @(negedge clk);
      req_i = 2'b01; cmd_i = {1'b0, 32'h4000_0100, 32'h0};
      apb.pready = 1'b0;
      repeat (3) @(negedge clk);
      chk("t6_in_access", 64'(apb.psel & apb.penable), 64'd1);
      #2 TRSTn = 1'b0;
      #1;
      chk("t6_bus_drop", 64'({apb.psel, apb.penable, ack_o}), 64'd0);
      chk("t6_resp", 64'(resp_o), 64'd0);
      req_i = 2'b00;
      @(negedge clk);
      TRSTn = 1'b1;
      model_reset();
      repeat (3) @(negedge clk);
      run("t6_after", 2'b01, {1'b1, 32'h4000_0200, 32'h7777_8888}, 0, 0, 32'h0, 0);

      // random mix
      for (int i = 0; i < 40; i++) begin
         int k;
         k = $urandom_range(0, 9);
         case (k)
            0, 1, 2, 3:
               run("rnd_rw", 2'b01, {1'($urandom), $urandom, $urandom}, $urandom_range(0, 4), 0,
                   $urandom, ($urandom_range(0, 3) == 0));
            4: run("rnd_status", 2'b10, acc_cmd(2'd0), 0, 0, 32'h0, 0);
            5: run("rnd_clear", 2'b10, acc_cmd(2'd1), 0, 0, 32'h0, 0);
            6: run("rnd_inc", 2'b10, acc_cmd(2'd2), $urandom_range(0, 3), 0, $urandom, 1'($urandom));
            7: run("rnd_rsvd", 2'b10, acc_cmd(2'd3), 0, 0, 32'h0, 0);
            8: run("rnd_proto", 2'b11, {1'($urandom), $urandom, $urandom}, 0, 0, 32'h0, 0);
            default:
               run("rnd_hang", 2'b01, {1'($urandom), $urandom, $urandom}, 0, 1, 32'h0, 0);
         endcase
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
